// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 block scheduler.
// Holds FSM/pending enums, the MD5 initial chaining value and a byte-swap helper.
package md5_pkg;

    typedef enum logic [1:0] {S_FILL, S_PAD, S_HASH, S_WAIT} state_t;
    typedef enum logic [1:0] {NONE, PAD80, LEN} pend_t;

    localparam logic [127:0] MD5_IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/md5_pad_unit.sv
// Combinational MD5 padding of a 16-word block: tail-byte masking, 0x80 marker,
// zero fill and the 64-bit length, or a request for one extra block.
module md5_pad_unit
    import md5_pkg::*;
(
    input  logic [15:0][31:0] blk,
    input  logic [3:0]        p,
    input  logic [2:0]        n,
    input  logic [63:0]       len,
    output logic [15:0][31:0] padded,
    output logic              is_final,
    output pend_t             pend
);

    // 16 means the marker spilled past the end of this block
    logic [4:0] idx80;
    assign idx80 = (n == 3'd4) ? ({1'b0, p} + 5'd1) : {1'b0, p};

    always_comb begin
        padded = blk;
        for (int j = 0; j < 16; j++) begin
            if (5'(j) == {1'b0, p}) begin
                for (int b = 0; b < 4; b++) begin
                    if (3'(b) >= n)
                        padded[j][8*b +: 8] = (3'(b) == n) ? 8'h80 : 8'h00;
                end
            end else if (5'(j) == idx80) begin
                padded[j] = 32'h0000_0080;
            end else if (5'(j) > idx80) begin
                padded[j] = '0;
            end
        end
        if (idx80 <= 5'd13) begin
            padded[14] = len[31:0];
            padded[15] = len[63:32];
            is_final   = 1'b1;
            pend       = NONE;
        end else begin
            is_final = 1'b0;
            pend     = (idx80 == 5'd16) ? PAD80 : LEN;
        end
    end

endmodule

// File: rtl/md5_block_sched.sv
// MD5 message-stream controller: packs words into blocks, pads, drives the round
// core one block at a time and accumulates the chaining value into the digest.
module md5_block_sched
    import md5_pkg::*;
#(
    parameter int           LEN_W = 64,
    parameter logic [127:0] IV    = MD5_IV
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [31:0]  in_data_i,
    input  logic         in_last_i,
    input  logic [2:0]   in_bytes_i,
    output logic         core_start_o,
    output logic [511:0] core_block_o,
    output logic [127:0] core_iv_o,
    input  logic         core_done_i,
    input  logic [127:0] core_digest_i,
    output logic [127:0] hash_o,
    output logic         hash_valid_o,
    output logic         busy_o
);

    state_t            state, state_nxt;
    pend_t             pend, pad_pend;
    logic [3:0]        wcnt, pad_p;
    logic [2:0]        pad_n;
    logic [LEN_W-1:0]  len;
    logic [63:0]       len64;
    logic              fin, pad_fin, acc;
    logic [15:0][31:0] blk, padded;
    logic [3:0][31:0]  chain, sum;

    assign len64        = 64'(len);
    assign acc          = in_valid_i && in_ready_o;
    assign core_block_o = blk;
    assign core_iv_o    = chain;
    assign busy_o       = (state != S_FILL) || (wcnt != 4'd0);

    always_comb begin
        for (int k = 0; k < 4; k++)
            sum[k] = chain[k] + core_digest_i[32*k +: 32];
    end

    md5_pad_unit u_pad (
        .blk      (blk),
        .p        (pad_p),
        .n        (pad_n),
        .len      (len64),
        .padded   (padded),
        .is_final (pad_fin),
        .pend     (pad_pend)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL: if (acc) begin
                if (in_last_i)          state_nxt = S_PAD;
                else if (wcnt == 4'd15) state_nxt = S_HASH;
            end
            S_PAD:  state_nxt = S_HASH;
            S_HASH: state_nxt = S_WAIT;
            S_WAIT: if (core_done_i) begin
                if (!fin && pend != NONE) state_nxt = S_HASH;
                else                      state_nxt = S_FILL;
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // in_ready_o is forced low by the async reset itself, not only by the state
    always_comb begin
        in_ready_o   = (state == S_FILL) && rst_i;
        core_start_o = (state == S_HASH);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wcnt         <= '0;
            len          <= '0;
            pend         <= NONE;
            fin          <= 1'b0;
            blk          <= '0;
            pad_p        <= '0;
            pad_n        <= '0;
            chain        <= IV;
            hash_o       <= '0;
            hash_valid_o <= 1'b0;
        end else begin
            hash_valid_o <= 1'b0;
            case (state)
                S_FILL: if (acc) begin
                    blk[wcnt] <= in_data_i;
                    if (in_last_i) begin
                        len   <= len + LEN_W'({in_bytes_i, 3'b000});
                        pad_p <= wcnt;
                        pad_n <= in_bytes_i;
                    end else begin
                        len  <= len + LEN_W'(32);
                        wcnt <= wcnt + 4'd1;
                        fin  <= 1'b0;
                    end
                end
                S_PAD: begin
                    blk  <= padded;
                    fin  <= pad_fin;
                    pend <= pad_pend;
                end
                S_WAIT: if (core_done_i) begin
                    blk <= '0;
                    if (fin) begin
                        hash_o       <= {bswap32(sum[3]), bswap32(sum[2]), bswap32(sum[1]), bswap32(sum[0])};
                        hash_valid_o <= 1'b1;
                        chain        <= IV;
                        len          <= '0;
                        wcnt         <= '0;
                        fin          <= 1'b0;
                    end else begin
                        chain <= sum;
                        // trailer block: length words, plus the marker if it did not fit
                        if (pend != NONE) begin
                            blk[14] <= len64[31:0];
                            blk[15] <= len64[63:32];
                            if (pend == PAD80) blk[0] <= 32'h0000_0080;
                            fin  <= 1'b1;
                            pend <= NONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
